// File: rtl/pulse_stretcher.sv
// pulse_stretcher
//   Turns a single-cycle trigger into a registered high pulse of programmable
//   length. After each pulse it holds the output low for a guard gap. It also
//   supports retriggering during a pulse and aborting an active pulse.
//
// Ports
//   clk          sole clock, rising edge
//   rst          asynchronous reset, active low
//   i_trig       single-cycle trigger request
//   i_width      requested high time in clk cycles; sampled only on an accepted trigger
//   i_retrig_en  1: a trigger during a pulse reloads the length; 0: it is rejected
//   i_abort      ends an active pulse at once
//   o_level      stretched pulse (registered)
//   o_busy       high while in HIGH or GAP (registered)
//   o_done       one-cycle strobe on the first low cycle after natural expiry
//   o_overrun    one-cycle strobe for every rejected trigger
//
// state | meaning
// IDLE  | output low, waiting for a trigger with non-zero width
// HIGH  | output high, pulse counter running down to zero
// GAP   | output low guard time of GAP_CYCLES cycles, triggers rejected

module pulse_stretcher #(
  parameter int CNT_W      = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_trig,
  input  logic [CNT_W-1:0] i_width,
  input  logic             i_retrig_en,
  input  logic             i_abort,
  output logic             o_level,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_overrun
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam bit               HAS_GAP  = (GAP_CYCLES > 0);
  // The gap counter holds "cycles remaining minus one", so GAP lasts GAP_LOAD+1 cycles.
  localparam logic [7:0]       GAP_LOAD = HAS_GAP ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       gap_q, gap_d;
  logic             level_d, busy_d, done_d, overrun_d;

  logic             width_ok;
  logic             reload;
  state_t           end_state;

  assign width_ok  = (i_width != '0);
  assign reload    = i_trig & i_retrig_en & width_ok;
  assign end_state = HAS_GAP ? ST_GAP : ST_IDLE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      gap_q     <= '0;
      o_level   <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      o_level   <= level_d;
      o_busy    <= busy_d;
      o_done    <= done_d;
      o_overrun <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    level_d   = 1'b0;
    done_d    = 1'b0;
    overrun_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Zero-width triggers are dropped silently here, not flagged as overrun.
        if (i_trig && width_ok) begin
          state_d = ST_HIGH;
          cnt_d   = i_width - CNT_ONE;
          level_d = 1'b1;
        end
      end

      ST_HIGH: begin
        if (i_abort) begin
          // Abort wins over any trigger in the same cycle; that trigger is lost.
          state_d   = end_state;
          cnt_d     = '0;
          gap_d     = GAP_LOAD;
          overrun_d = i_trig;
        end else begin
          overrun_d = i_trig & ~reload;
          if (reload) begin
            // A reload also overrides expiry on the last high cycle, so the pulse has no low glitch.
            cnt_d   = i_width - CNT_ONE;
            level_d = 1'b1;
          end else if (cnt_q == '0) begin
            state_d = end_state;
            gap_d   = GAP_LOAD;
            done_d  = 1'b1;
          end else begin
            cnt_d   = cnt_q - CNT_ONE;
            level_d = 1'b1;
          end
        end
      end

      ST_GAP: begin
        overrun_d = i_trig;
        if (gap_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        gap_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
module tb_pulse_stretcher;

  localparam int CNT_W = 4;
  localparam int GAP   = 2;

  // expected output vector bits: {o_level, o_busy, o_done, o_overrun}
  localparam logic [3:0] Z  = 4'b0000;
  localparam logic [3:0] LB = 4'b1100;
  localparam logic [3:0] BD = 4'b0110;
  localparam logic [3:0] B  = 4'b0100;
  localparam logic [3:0] BO = 4'b0101;
  localparam logic [3:0] LO = 4'b1101;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_trig = 1'b0;
  logic [CNT_W-1:0] i_width = '0;
  logic             i_retrig_en = 1'b0;
  logic             i_abort = 1'b0;
  logic             o_level, o_busy, o_done, o_overrun;

  int checks = 0;
  int errors = 0;
  string scen = "init";
  int step_no = 0;
  logic [3:0] exp_q[$];

  pulse_stretcher #(.CNT_W(CNT_W), .GAP_CYCLES(GAP)) dut (
    .clk(clk),
    .rst(rst),
    .i_trig(i_trig),
    .i_width(i_width),
    .i_retrig_en(i_retrig_en),
    .i_abort(i_abort),
    .o_level(o_level),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s step %0d: observed {lvl,busy,done,ovr}=%b expected %b", tag, step_no, obs, expv);
    end
  endtask

  task automatic expect_n(input logic [3:0] v, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(v);
  endtask

  // Drive one cycle of stimulus, then compare the registered outputs against the next expected entry.
  task automatic step(input logic trig, input logic [CNT_W-1:0] w, input logic re, input logic ab);
    logic [3:0] expv;
    i_trig = trig;
    i_width = w;
    i_retrig_en = re;
    i_abort = ab;
    @(posedge clk);
    #1;
    step_no++;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s step %0d: scoreboard empty, observed %b expected an entry", scen, step_no,
               {o_level, o_busy, o_done, o_overrun});
    end else begin
      expv = exp_q.pop_front();
      chk(scen, {o_level, o_busy, o_done, o_overrun}, expv);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic begin_scen(input string s);
    scen = s;
    step_no = 0;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: %0d leftover entries, expected 0", s, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #2 rst = 1'b0;
    #1 chk("reset", {o_level, o_busy, o_done, o_overrun}, Z);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // width 5 pulse, 2-cycle gap, then trigger on the first idle cycle after the gap
    begin_scen("basic_w5");
    expect_n(LB, 5); expect_n(BD, 1); expect_n(B, 1); expect_n(Z, 1);
    expect_n(LB, 1); expect_n(BD, 1); expect_n(B, 1); expect_n(Z, 1);
    step(1'b1, 4'd5, 1'b0, 1'b0);
    idle(7);
    step(1'b1, 4'd1, 1'b0, 1'b0);
    idle(3);

    // zero-width trigger and abort while idle do nothing
    begin_scen("idle_noop");
    expect_n(Z, 3);
    step(1'b1, 4'd0, 1'b1, 1'b0);
    step(1'b0, 4'd3, 1'b0, 1'b1);
    idle(1);

    // retrigger with width 3 on the 2nd high cycle of a width 4 pulse -> 5 high cycles, one done
    begin_scen("retrig");
    expect_n(LB, 5); expect_n(BD, 1); expect_n(B, 1); expect_n(Z, 1);
    step(1'b1, 4'd4, 1'b1, 1'b0);
    idle(1);
    step(1'b1, 4'd3, 1'b1, 1'b0);
    idle(5);

    // retrigger on the last high cycle extends without a low glitch
    begin_scen("retrig_last");
    expect_n(LB, 4); expect_n(BD, 1); expect_n(B, 1); expect_n(Z, 1);
    step(1'b1, 4'd2, 1'b1, 1'b0);
    idle(1);
    step(1'b1, 4'd2, 1'b1, 1'b0);
    idle(4);

    // retrigger disabled: overrun in HIGH and in GAP, pulse length unchanged
    begin_scen("overrun");
    expect_n(LB, 1); expect_n(LO, 1); expect_n(LB, 1); expect_n(BD, 1);
    expect_n(BO, 1); expect_n(Z, 2);
    step(1'b1, 4'd3, 1'b0, 1'b0);
    step(1'b1, 4'd5, 1'b0, 1'b0);
    idle(2);
    step(1'b1, 4'd5, 1'b0, 1'b0);
    idle(2);

    // abort with simultaneous trigger on the 3rd high cycle
    begin_scen("abort");
    expect_n(LB, 3); expect_n(BO, 1); expect_n(B, 1); expect_n(Z, 2);
    step(1'b1, 4'd10, 1'b1, 1'b0);
    idle(2);
    step(1'b1, 4'd3, 1'b1, 1'b1);
    idle(3);

    // abort during GAP has no effect
    begin_scen("abort_gap");
    expect_n(LB, 1); expect_n(BD, 1); expect_n(B, 1); expect_n(Z, 1);
    step(1'b1, 4'd1, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    idle(1);

    // all-ones width gives 15 high cycles; zero-width retrigger mid-pulse is an overrun
    begin_scen("max_width");
    expect_n(LB, 4); expect_n(LO, 1); expect_n(LB, 10);
    expect_n(BD, 1); expect_n(B, 1); expect_n(Z, 1);
    step(1'b1, 4'd15, 1'b1, 1'b0);
    idle(3);
    step(1'b1, 4'd0, 1'b1, 1'b0);
    idle(13);

    // asynchronous reset mid-pulse, then a fresh 2-cycle pulse
    begin_scen("reset_mid");
    expect_n(LB, 2);
    step(1'b1, 4'd5, 1'b0, 1'b0);
    idle(1);
    #2 rst = 1'b0;
    #1 chk("reset_mid_async", {o_level, o_busy, o_done, o_overrun}, Z);
    @(posedge clk);
    #1 chk("reset_mid_held", {o_level, o_busy, o_done, o_overrun}, Z);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    begin_scen("after_reset");
    expect_n(LB, 2); expect_n(BD, 1); expect_n(B, 1); expect_n(Z, 1);
    step(1'b1, 4'd2, 1'b0, 1'b0);
    idle(4);

    begin_scen("end");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_stretcher.md
PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 The block SHALL provide parameter CNT_W, default 16, the width of the pulse-length counter and of i_width.
REQ-002 The block SHALL provide parameter GAP_CYCLES, default 2, the minimum number of low cycles enforced after every pulse (0 allowed, max 255).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low; the block is held in reset while rst==0.
REQ-005 i_trig  input  1  single-cycle trigger request, e.g. from the rising-edge detector.
REQ-006 i_width  input  CNT_W  requested high time in clk cycles; sampled only when a trigger is accepted.
REQ-007 i_retrig_en  input  1  1 = a trigger during a pulse reloads the counter; 0 = such a trigger is rejected.
REQ-008 i_abort  input  1  terminates an active pulse immediately.
REQ-009 o_level  output  1  stretched pulse; registered.
REQ-010 o_busy  output  1  high in states HIGH and GAP.
REQ-011 o_done  output  1  one-cycle pulse marking natural completion of a pulse.
REQ-012 o_overrun  output  1  one-cycle pulse marking a rejected trigger.

Function
REQ-013 The block SHALL implement three states: IDLE, HIGH and GAP, with a down-counter of CNT_W bits and a gap counter of 8 bits.
REQ-014 In IDLE, i_trig==1 with i_width==W>=1 SHALL latch W, enter HIGH and drive o_level=1 from the next cycle for exactly W cycles.
REQ-015 In IDLE, i_trig==1 with i_width==0 SHALL be ignored: no state change, o_done=0, o_overrun=0.
REQ-016 In HIGH, the counter SHALL decrement each cycle; when it expires, the block SHALL drive o_level=0 the next cycle and enter GAP, or enter IDLE if GAP_CYCLES==0.
REQ-017 o_done SHALL be 1 for exactly the first cycle in which o_level is low after natural expiry, and never after an abort.
REQ-018 In HIGH, i_trig with i_retrig_en=1 and i_width=W>=1 SHALL reload the counter so that o_level stays high for W further cycles counted from the next cycle, with no low glitch; this includes a trigger on the last high cycle.
REQ-019 In HIGH, i_trig with i_retrig_en=0, or with i_width==0, SHALL leave the pulse unchanged and pulse o_overrun for one cycle.
REQ-020 In HIGH, i_abort==1 SHALL drive o_level=0 the next cycle and enter GAP (IDLE if GAP_CYCLES==0), with o_done=0.
REQ-021 i_abort SHALL take priority over a simultaneous i_trig, and in that case o_overrun SHALL pulse.
REQ-022 GAP SHALL last exactly GAP_CYCLES cycles with o_level=0, after which the block SHALL enter IDLE.
REQ-023 i_trig in GAP SHALL be rejected with a one-cycle o_overrun pulse; i_abort in GAP or IDLE SHALL have no effect.
REQ-024 A trigger arriving on the first IDLE cycle after GAP SHALL be accepted, giving a minimum low time of GAP_CYCLES+1 cycles between pulses when GAP_CYCLES>0.
REQ-025 The output o_busy SHALL equal (state != IDLE), and all outputs SHALL be driven from flip-flops.
REQ-026 The counter SHALL never wrap: a width of all-ones SHALL give exactly 2^CNT_W-1 high cycles.

Reset
REQ-027 On rst==0, the block SHALL immediately enter IDLE, clear both counters, and force o_level, o_busy, o_done and o_overrun to 0, regardless of clk.
REQ-028 Reset asserted mid-pulse SHALL end the pulse without asserting o_done.
REQ-029 After rst rises, the first i_trig sampled SHALL be accepted as from IDLE.

Verification
REQ-030 Scenario: GAP_CYCLES=2, i_trig at cycle 10 with i_width=5 -> o_level high in cycles 11-15; o_done=1 in cycle 16; o_busy high in cycles 11-17; low from cycle 18.
REQ-031 Scenario: i_width=4, i_retrig_en=1, second trigger with i_width=3 on the 2nd high cycle -> o_level continuously high for 5 cycles; exactly one o_done.
REQ-032 Scenario: i_retrig_en=0, trigger during HIGH and another during GAP -> two separate one-cycle o_overrun pulses; pulse length unchanged.
REQ-033 Scenario: i_width=10, i_abort on the 3rd high cycle together with i_trig -> o_level low on the next cycle; o_done never asserted; one o_overrun pulse.
REQ-034 Scenario: i_width=0 trigger in IDLE -> all outputs stay 0; CNT_W=4 with i_width=15 -> exactly 15 high cycles.
REQ-035 Scenario: rst driven low asynchronously mid-pulse -> all outputs 0 before the next clk edge; after rst rises, i_trig with i_width=2 -> 2-cycle pulse.
